// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core load/store stage and the debug loader.
// Round-robin on ties, one access per grant, read data returned MEM_LAT cycles after issue.
module dmem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_stall,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t      r_state;
    logic        r_last_gnt;
    logic        r_gnt;
    logic [2:0]  r_cnt;
    logic        w_win;
    logic        w_we;
    // requester id: 0 = core, 1 = debug; on a tie the one not served last wins
    assign w_win      = (c_req && d_req) ? ~r_last_gnt : d_req;
    assign w_we       = w_win ? d_we : c_we;
    assign core_stall = c_req & ~c_done;
    assign busy       = (r_state != IDLE);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_gnt      <= 1'b0;
            r_cnt      <= '0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            c_done     <= 1'b0;
            d_done     <= 1'b0;
            c_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: if (c_req || d_req) begin
                    r_gnt      <= w_win;
                    r_last_gnt <= w_win;
                    mem_wr     <= w_we;
                    mem_rd     <= ~w_we;
                    mem_addr   <= w_win ? d_addr : c_addr;
                    mem_wdata  <= w_win ? d_wdata : c_wdata;
                    r_state    <= ISSUE;
                end
                ISSUE: begin
                    mem_wr <= 1'b0;
                    mem_rd <= 1'b0;
                    r_cnt  <= 3'(MEM_LAT);
                    if (mem_wr) begin
                        c_done  <= ~r_gnt;
                        d_done  <= r_gnt;
                        r_state <= DONE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        if (r_gnt) d_rdata <= mem_rdata;
                        else       c_rdata <= mem_rdata;
                        c_done  <= ~r_gnt;
                        d_done  <= r_gnt;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    c_done  <= 1'b0;
                    d_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter at MEM_LAT=1 (instance a) and MEM_LAT=4 (instance b).
module tb_dmem_arbiter;
    logic        clk, reset;
    logic        c_req, c_we, d_req, d_we;
    logic [8:0]  c_addr, d_addr;
    logic [31:0] c_wdata, d_wdata, mem_rdata;
    logic        a_c_done, a_d_done, a_mem_wr, a_mem_rd, a_core_stall, a_busy;
    logic [31:0] a_c_rdata, a_d_rdata, a_mem_wdata;
    logic [8:0]  a_mem_addr;
    logic        b_c_req, b_c_we;
    logic [8:0]  b_c_addr;
    logic [31:0] b_mem_rdata;
    logic        b_c_done, b_d_done, b_mem_wr, b_mem_rd, b_core_stall, b_busy;
    logic [31:0] b_c_rdata, b_d_rdata, b_mem_wdata;
    logic [8:0]  b_mem_addr;
    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(1)) u_a (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(a_c_done), .c_rdata(a_c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(a_d_done), .d_rdata(a_d_rdata),
        .mem_wr(a_mem_wr), .mem_rd(a_mem_rd), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
        .core_stall(a_core_stall), .busy(a_busy)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(4)) u_b (
        .clk(clk), .reset(reset),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(32'h0),
        .c_done(b_c_done), .c_rdata(b_c_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(9'h0), .d_wdata(32'h0),
        .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_wr(b_mem_wr), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .core_stall(b_core_stall), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order[$];
        int nc, nd;
        reset = 1'b0;
        {c_req, c_we, d_req, d_we} = '0;
        c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0; mem_rdata = '0;
        b_c_req = 1'b0; b_c_we = 1'b0; b_c_addr = '0; b_mem_rdata = '0;
        // 1: reset, then core read at MEM_LAT=1
        repeat (3) step();
        chk("rst_busy", a_busy, 0);
        chk("rst_strobes", {a_mem_wr, a_mem_rd, a_c_done, a_d_done}, 0);
        reset = 1'b1;
        step();
        chk("post_rst_outs", {a_mem_wr, a_mem_rd, a_c_done, a_d_done, a_busy, a_core_stall}, 0);
        chk("post_rst_addr", a_mem_addr, 0);
        chk("post_rst_wdata", a_mem_wdata, 0);
        chk("post_rst_crdata", a_c_rdata, 0);
        chk("post_rst_drdata", a_d_rdata, 0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010; mem_rdata = 32'hDEADBEEF;
        #1 chk("t1_stall_req", a_core_stall, 1);
        step();
        chk("t1_issue_rd", {a_mem_rd, a_mem_wr}, 2'b10);
        chk("t1_issue_addr", a_mem_addr, 9'h010);
        chk("t1_issue_busy", a_busy, 1);
        step();
        chk("t1_wait_rd", a_mem_rd, 0);
        chk("t1_wait_done", a_c_done, 0);
        chk("t1_wait_stall", a_core_stall, 1);
        step();
        chk("t1_done", a_c_done, 1);
        chk("t1_rdata", a_c_rdata, 32'hDEADBEEF);
        chk("t1_stall_off", a_core_stall, 0);
        c_req = 1'b0;
        step();
        chk("t1_done_pulse", a_c_done, 0);
        chk("t1_idle", a_busy, 0);
        // 2: debug write
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h1FF; d_wdata = 32'h12345678;
        step();
        chk("t2_wr", {a_mem_wr, a_mem_rd}, 2'b10);
        chk("t2_addr", a_mem_addr, 9'h1FF);
        chk("t2_wdata", a_mem_wdata, 32'h12345678);
        step();
        chk("t2_wr_off", a_mem_wr, 0);
        chk("t2_ddone", a_d_done, 1);
        chk("t2_cdone", a_c_done, 0);
        chk("t2_crdata", a_c_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        step();
        chk("t2_ddone_pulse", a_d_done, 0);
        // 3: both requesting, four grants alternate starting with core
        c_req = 1'b1; d_req = 1'b1; c_we = 1'b1; d_we = 1'b1;
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            step();
            if (a_c_done && a_d_done) chk("t3_both_done", 1, 0);
            if (a_c_done) order.push_back(0);
            if (a_d_done) order.push_back(1);
        end
        c_req = 1'b0; d_req = 1'b0;
        chk("t3_grants", order.size(), 4);
        nc = 0; nd = 0;
        foreach (order[k]) begin
            chk($sformatf("t3_order%0d", k), order[k], k % 2);
            if (order[k] == 0) nc++; else nd++;
        end
        chk("t3_core_cnt", nc, 2);
        chk("t3_dbg_cnt", nd, 2);
        step(); step();
        chk("t3_idle", a_busy, 0);
        // 6: addr change after grant; debug request during core wait
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h020; mem_rdata = 32'hA5A5A5A5;
        step();
        chk("t6_issue_addr", a_mem_addr, 9'h020);
        c_addr = 9'h030; d_req = 1'b1; d_we = 1'b0; d_addr = 9'h055;
        step();
        chk("t6_wait_addr", a_mem_addr, 9'h020);
        chk("t6_wait_rd", a_mem_rd, 0);
        step();
        chk("t6_cdone", a_c_done, 1);
        chk("t6_crdata", a_c_rdata, 32'hA5A5A5A5);
        chk("t6_ddone_quiet", a_d_done, 0);
        c_req = 1'b0;
        step();
        chk("t6_idle_no_rd", a_mem_rd, 0);
        step();
        chk("t6_dgrant_rd", a_mem_rd, 1);
        chk("t6_dgrant_addr", a_mem_addr, 9'h055);
        mem_rdata = 32'h0BADF00D;
        step(); step();
        chk("t6_ddone", a_d_done, 1);
        chk("t6_drdata", a_d_rdata, 32'h0BADF00D);
        chk("t6_crdata_kept", a_c_rdata, 32'hA5A5A5A5);
        d_req = 1'b0;
        step();
        // 4: MEM_LAT=4 read, data only from the 4th wait edge
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 9'h0AA; b_mem_rdata = 32'h11111111;
        step();
        chk("t4_rd", b_mem_rd, 1);
        chk("t4_addr", b_mem_addr, 9'h0AA);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) b_mem_rdata = 32'hCAFEF00D;
            step();
            if (i < 4) chk($sformatf("t4_wait%0d_done", i), {b_c_done, b_mem_rd}, 0);
            if (i < 4) chk($sformatf("t4_wait%0d_rdata", i), b_c_rdata, 0);
        end
        chk("t4_pre_done", b_c_done, 0);
        step();
        chk("t4_done", b_c_done, 1);
        chk("t4_rdata", b_c_rdata, 32'hCAFEF00D);
        b_c_req = 1'b0; b_mem_rdata = 32'h99999999;
        step();
        chk("t4_done_off", b_c_done, 0);
        chk("t4_rdata_hold", b_c_rdata, 32'hCAFEF00D);
        // 5: reset during wait of a core read
        b_c_req = 1'b1; b_c_addr = 9'h0BB; b_mem_rdata = 32'h22222222;
        step(); step(); step();
        chk("t5_in_wait", b_busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_busy", b_busy, 0);
        chk("t5_async_strobes", {b_mem_rd, b_mem_wr, b_c_done}, 0);
        chk("t5_async_addr", b_mem_addr, 0);
        b_c_req = 1'b0;
        nc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) reset = 1'b1;
            step();
            if (b_c_done) nc++;
        end
        chk("t5_no_done", nc, 0);
        b_c_req = 1'b1; b_c_addr = 9'h0CC; b_mem_rdata = 32'h33333333;
        step();
        chk("t5_new_rd", b_mem_rd, 1);
        chk("t5_new_addr", b_mem_addr, 9'h0CC);
        repeat (4) step();
        chk("t5_new_pre", b_c_done, 0);
        step();
        chk("t5_new_done", b_c_done, 1);
        chk("t5_new_rdata", b_c_rdata, 32'h33333333);
        b_c_req = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
